// File: rtl/phy_pkg.sv
// Shared PHY constants: comma symbol, frame size and transmitter state encoding.
package phy_pkg;

    localparam logic [7:0] COMMA_BC   = 8'hBC;
    localparam int         FRAME_BITS = 8;

    // Transmitter states (1-bit encoding, shared with the receiver stage)
    localparam logic [0:0] TRAIN = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    // Bit of a frame sent at a given bit_cnt position (MSB goes first)
    function automatic logic frame_bit(input logic [7:0] frame, input logic [2:0] bit_cnt);
        return frame[3'd7 - bit_cnt];
    endfunction

endpackage

// File: rtl/phy_tx_fifo.sv
// Small byte FIFO between the link layer and the serialiser.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// the head entry is read combinationally so the serialiser can pop and use
// it on the same edge.
module phy_tx_fifo
    import phy_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    input  logic                  push,
    input  logic [FRAME_BITS-1:0] push_data,
    input  logic                  pop,
    output logic [FRAME_BITS-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic                  wr_en;
    logic                  rd_en;

    // Guard both strobes here too so a careless caller cannot corrupt pointers
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk_32f) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Transmit-side PHY: buffers bytes from the link layer and serialises them
// MSB-first, one bit per clk_32f. Commas (0xBC) fill every frame without data,
// and after reset a fixed burst of commas trains the receiver before any
// queued data is released.
module paralelo_serial_tx
    import phy_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int NUM_IDLE_INIT = 5
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       full,
    output logic       data_out,
    output logic       frame_start,
    output logic       tx_active,
    output logic       overflow
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int IW    = (NUM_IDLE_INIT < 1) ? 1 : $clog2(NUM_IDLE_INIT + 1);
    localparam logic [IW-1:0] IDLE_TARGET = IW'(NUM_IDLE_INIT);

    logic [CNT_W-1:0] bit_cnt_reg;
    logic [7:0]       frame_reg;
    logic [0:0]       state_reg;
    logic [0:0]       state_next;
    logic [IW-1:0]    idle_cnt_reg;
    logic [IW-1:0]    idle_cnt_next;
    logic             data_out_reg;
    logic             frame_start_reg;
    logic             tx_active_reg;
    logic             overflow_reg;

    logic             boundary;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [7:0]       next_frame;

    phy_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (full)
    );

    assign boundary  = (bit_cnt_reg == '0);
    // full is sampled before any pop on this edge, so a write at a popping
    // boundary while full is still rejected
    assign fifo_push = valid_in && !full;

    // Training sequencer: count comma frames, switch to RUN on the boundary
    // after the last one so that boundary already behaves as RUN
    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        if (boundary && (state_reg == TRAIN)) begin
            if (idle_cnt_reg == IDLE_TARGET) begin
                state_next = RUN;
            end else begin
                idle_cnt_next = idle_cnt_reg + 1'b1;
            end
        end
    end

    // A pop only happens at a RUN boundary with data present; an empty FIFO
    // (including one being written this very edge) yields a comma
    assign fifo_pop   = boundary && (state_next == RUN) && !fifo_empty;
    assign next_frame = fifo_pop ? fifo_head : COMMA_BC;

    // Serialiser, sequencer state and sticky overflow flag
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt_reg     <= '0;
            frame_reg       <= '0;
            state_reg       <= TRAIN;
            idle_cnt_reg    <= '0;
            data_out_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            tx_active_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idle_cnt_reg  <= idle_cnt_next;
            tx_active_reg <= (state_next == RUN);
            overflow_reg  <= overflow_reg | (valid_in & full);
            if (boundary) begin
                frame_reg       <= next_frame;
                data_out_reg    <= next_frame[7];
                frame_start_reg <= 1'b1;
                bit_cnt_reg     <= CNT_W'(1);
            end else begin
                data_out_reg    <= frame_bit(frame_reg, bit_cnt_reg);
                frame_start_reg <= 1'b0;
                bit_cnt_reg     <= bit_cnt_reg + 1'b1;
            end
        end
    end

    assign data_out    = data_out_reg;
    assign frame_start = frame_start_reg;
    assign tx_active   = tx_active_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Testbench for paralelo_serial_tx: a frame collector rebuilds bytes from
// data_out/frame_start, tests push expected frames to a queue and compare
// them against the collected frames.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       full;
    logic       data_out;
    logic       frame_start;
    logic       tx_active;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    paralelo_serial_tx #(
        .FIFO_DEPTH    (4),
        .NUM_IDLE_INIT (5)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .full        (full),
        .data_out    (data_out),
        .frame_start (frame_start),
        .tx_active   (tx_active),
        .overflow    (overflow)
    );

    always #5 clk_32f = ~clk_32f;

    // Frame collector: samples on the falling edge, away from DUT updates
    initial begin
        logic [7:0] shift;
        int         cnt;
        shift = '0;
        cnt   = 0;
        forever begin
            @(negedge clk_32f);
            if (reset) begin
                cnt = 0;
            end else if (frame_start) begin
                shift = {7'b0, data_out};
                cnt   = 1;
            end else if (cnt != 0) begin
                shift = {shift[6:0], data_out};
                cnt   = cnt + 1;
            end
            if (cnt == 8) begin
                rx_q.push_back(shift);
                cnt = 0;
            end
        end
    end

    task automatic wait_frame(output bit ok, output logic [7:0] f);
        ok = 1'b0;
        f  = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rx_q.size() > 0) begin
                f  = rx_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge clk_32f);
            end
        end
    endtask

    task automatic sync_boundary(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk_32f);
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (3) @(negedge clk_32f);
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_32f);
        n_cmp++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
        n_cmp++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_tx_active got=%b exp=0", tx_active); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_training();
        logic [7:0] comma_v;
        logic       exp_bit;
        comma_v = COMMA;
        do_reset();
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk_32f);
            exp_bit = comma_v[7 - (cyc % 8)];
            n_cmp++; if (data_out !== exp_bit) begin n_fail++; $display("FAIL train_bit cyc=%0d got=%b exp=%b", cyc, data_out, exp_bit); end
            n_cmp++; if (frame_start !== (cyc % 8 == 0)) begin n_fail++; $display("FAIL train_fs cyc=%0d got=%b exp=%b", cyc, frame_start, (cyc % 8 == 0)); end
            n_cmp++; if (tx_active !== (cyc >= 40)) begin n_fail++; $display("FAIL train_active cyc=%0d got=%b exp=%b", cyc, tx_active, (cyc >= 40)); end
        end
        $display("test_training: 64 cycles of comma pattern checked");
    endtask

    task automatic test_train_push();
        bit ok;
        logic [7:0] f, e;
        do_reset();
        repeat (3) @(negedge clk_32f);
        data_in = 8'h5A; valid_in = 1'b1;
        @(negedge clk_32f);
        valid_in = 1'b0;
        repeat (5) exp_q.push_back(COMMA);
        exp_q.push_back(8'h5A);
        exp_q.push_back(COMMA);
        for (int k = 0; k < 7; k++) begin
            e = exp_q.pop_front();
            wait_frame(ok, f);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL tp_frame%0d timeout exp=%02h", k, e); end
            else if (f !== e) begin n_fail++; $display("FAIL tp_frame%0d got=%02h exp=%02h", k, f, e); end
            else $display("test_train_push: frame %0d = %02h", k, f);
        end
        n_cmp++; if (tx_active !== 1'b1) begin n_fail++; $display("FAIL tp_active got=%b exp=1", tx_active); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] f, e;
        logic [7:0] bytes_v [5];
        bytes_v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        sync_boundary(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ov_sync got=timeout exp=frame_start"); end
        rx_q.delete();
        exp_q.push_back(COMMA);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL ov_full3 got=%b exp=0", full); end
            end
            if (k == 4) begin
                n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ov_full4 got=%b exp=1", full); end
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ov_early got=%b exp=0", overflow); end
            end
            data_in = bytes_v[k]; valid_in = 1'b1;
            if (k < 4) exp_q.push_back(bytes_v[k]);
            @(negedge clk_32f);
        end
        valid_in = 1'b0;
        exp_q.push_back(COMMA);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_flag got=%b exp=1", overflow); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ov_full5 got=%b exp=1", full); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            wait_frame(ok, f);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL ov_frame%0d timeout exp=%02h", k, e); end
            else if (f !== e) begin n_fail++; $display("FAIL ov_frame%0d got=%02h exp=%02h", k, f, e); end
            else $display("test_overflow: frame %0d = %02h", k, f);
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [7:0] f, e;
        sync_boundary(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL sim_sync got=timeout exp=frame_start"); end
        rx_q.delete();
        repeat (7) @(negedge clk_32f);
        data_in = 8'hA5; valid_in = 1'b1;
        @(negedge clk_32f);
        valid_in = 1'b0;
        n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL sim_on_boundary got=%b exp=1", frame_start); end
        exp_q.push_back(COMMA);
        exp_q.push_back(COMMA);
        exp_q.push_back(8'hA5);
        exp_q.push_back(COMMA);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            wait_frame(ok, f);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL sim_frame%0d timeout exp=%02h", k, e); end
            else if (f !== e) begin n_fail++; $display("FAIL sim_frame%0d got=%02h exp=%02h", k, f, e); end
            else $display("test_simultaneous: frame %0d = %02h", k, f);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] f, e;
        sync_boundary(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rm_sync got=timeout exp=frame_start"); end
        data_in = 8'h11; valid_in = 1'b1; @(negedge clk_32f);
        data_in = 8'h22; @(negedge clk_32f);
        data_in = 8'h33; @(negedge clk_32f);
        valid_in = 1'b0;
        repeat (8) @(negedge clk_32f);
        // bit 4 of 0x11 is on the line now; reset lands on bit 3
        n_cmp++; if (data_out !== 1'b1) begin n_fail++; $display("FAIL rm_bit4 got=%b exp=1", data_out); end
        reset = 1'b1;
        @(negedge clk_32f);
        n_cmp++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL rm_data_out got=%b exp=0", data_out); end
        n_cmp++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL rm_tx_active got=%b exp=0", tx_active); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_overflow got=%b exp=0", overflow); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rm_full got=%b exp=0", full); end
        @(negedge clk_32f);
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk_32f);
        n_cmp++; if (frame_start !== 1'b1 || data_out !== 1'b1) begin n_fail++; $display("FAIL rm_restart got=fs%b/d%b exp=fs1/d1", frame_start, data_out); end
        // Queued bytes must be gone: training then commas only
        repeat (7) exp_q.push_back(COMMA);
        for (int k = 0; k < 7; k++) begin
            e = exp_q.pop_front();
            wait_frame(ok, f);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL rm_frame%0d timeout exp=%02h", k, e); end
            else if (f !== e) begin n_fail++; $display("FAIL rm_frame%0d got=%02h exp=%02h", k, f, e); end
            else $display("test_reset_mid: frame %0d = %02h", k, f);
        end
        n_cmp++; if (tx_active !== 1'b1) begin n_fail++; $display("FAIL rm_active got=%b exp=1", tx_active); end
    endtask

    task automatic test_loopback();
        bit ok;
        int n_valid;
        logic [7:0] f, e;
        n_valid = 0;
        sync_boundary(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL lb_sync got=timeout exp=frame_start"); end
        rx_q.delete();
        exp_q.push_back(COMMA);
        data_in = 8'h11; valid_in = 1'b1; exp_q.push_back(8'h11); @(negedge clk_32f);
        data_in = 8'h22; exp_q.push_back(8'h22); @(negedge clk_32f);
        data_in = 8'h33; exp_q.push_back(8'h33); @(negedge clk_32f);
        valid_in = 1'b0;
        exp_q.push_back(COMMA);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            wait_frame(ok, f);
            if (ok && f != COMMA) n_valid++;
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL lb_frame%0d timeout exp=%02h", k, e); end
            else if (f !== e) begin n_fail++; $display("FAIL lb_frame%0d got=%02h exp=%02h", k, f, e); end
            else $display("test_loopback: frame %0d = %02h valid=%0d", k, f, (f != COMMA));
        end
        n_cmp++; if (n_valid !== 3) begin n_fail++; $display("FAIL lb_valid_count got=%0d exp=3", n_valid); end
    endtask

    initial begin
        test_reset();
        test_training();
        test_train_push();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
